// File: rtl/short_preamble_gen.sv
`default_nettype none
// ============================================================================
// Module   : short_preamble_gen
// Brief    : L-STF (802.11a/g short training field) transmit generator.
//            Streams NUM_REPS repetitions of the 16-sample short symbol as
//            packed {I,Q} samples over a valid/ready interface, with optional
//            first-sample windowing and a per-burst gain shift.
// Revision : 1.0 - initial release
// ============================================================================
module short_preamble_gen #(
    parameter int NUM_REPS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic        abort,
    input  logic        window_en,
    input  logic [1:0]  scale_shift,
    output logic [31:0] sample_out,
    output logic        sample_out_valid,
    input  logic        sample_out_ready,
    output logic        sample_out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] c_LAST_REP = 4'(NUM_REPS - 1);
    localparam logic [3:0] c_LAST_K   = 4'd15;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state, w_state_n;
    logic [3:0]  r_k, w_k_n;
    logic [3:0]  r_rep, w_rep_n;
    logic        r_win, w_win_n;
    logic [1:0]  r_shift, w_shift_n;
    logic [31:0] r_sample, w_sample_n;
    logic        r_valid, w_valid_n;
    logic        r_last, w_last_n;
    logic        r_busy, w_busy_n;
    logic        r_done, w_done_n;

    logic        w_fire;
    logic [3:0]  w_k_inc;
    logic [3:0]  w_rep_inc;

    // Short-symbol table, {I,Q} at a scale of 2^14.
    function automatic logic [31:0] rom_sample(input logic [3:0] k);
        case (k)
            4'd0:    rom_sample = { 16'sd754,   16'sd754};
            4'd1:    rom_sample = {-16'sd2163,  16'sd33};
            4'd2:    rom_sample = {-16'sd213,  -16'sd1294};
            4'd3:    rom_sample = { 16'sd2343, -16'sd213};
            4'd4:    rom_sample = { 16'sd1507,  16'sd0};
            4'd5:    rom_sample = { 16'sd2343, -16'sd213};
            4'd6:    rom_sample = {-16'sd213,  -16'sd1294};
            4'd7:    rom_sample = {-16'sd2163,  16'sd33};
            4'd8:    rom_sample = { 16'sd754,   16'sd754};
            4'd9:    rom_sample = { 16'sd33,   -16'sd2163};
            4'd10:   rom_sample = {-16'sd1294, -16'sd213};
            4'd11:   rom_sample = {-16'sd213,   16'sd2343};
            4'd12:   rom_sample = { 16'sd0,     16'sd1507};
            4'd13:   rom_sample = {-16'sd213,   16'sd2343};
            4'd14:   rom_sample = {-16'sd1294, -16'sd213};
            default: rom_sample = { 16'sd33,   -16'sd2163};
        endcase
    endfunction

    // Gain shift cannot overflow 16 bits (max 2343 << 3); the window halves
    // after scaling so the halving keeps the scaled sign.
    function automatic logic [31:0] shape(input logic [31:0] raw,
                                          input logic [1:0]  sh,
                                          input logic        win);
        logic signed [15:0] i_c;
        logic signed [15:0] q_c;
        i_c = $signed(raw[31:16]) <<< sh;
        q_c = $signed(raw[15:0])  <<< sh;
        if (win) begin
            i_c = i_c >>> 1;
            q_c = q_c >>> 1;
        end
        shape = {i_c, q_c};
    endfunction

    assign w_fire    = r_valid & sample_out_ready;
    assign w_k_inc   = r_k + 4'd1;
    assign w_rep_inc = (r_k == c_LAST_K) ? r_rep + 4'd1 : r_rep;

    // Next-state and next-output logic; enable low holds everything.
    always_comb begin
        w_state_n  = r_state;
        w_k_n      = r_k;
        w_rep_n    = r_rep;
        w_win_n    = r_win;
        w_shift_n  = r_shift;
        w_sample_n = r_sample;
        w_valid_n  = r_valid;
        w_last_n   = r_last;
        w_busy_n   = r_busy;
        w_done_n   = 1'b0;
        if (enable) begin
            case (r_state)
                S_IDLE: begin
                    // abort in the same cycle cancels the request
                    if (start && !abort) begin
                        w_state_n  = S_RUN;
                        w_k_n      = 4'd0;
                        w_rep_n    = 4'd0;
                        w_win_n    = window_en;
                        w_shift_n  = scale_shift;
                        w_sample_n = shape(rom_sample(4'd0), scale_shift, window_en);
                        w_valid_n  = 1'b1;
                        w_last_n   = 1'b0;
                        w_busy_n   = 1'b1;
                    end
                end
                default: begin
                    if (abort || (w_fire && r_last)) begin
                        w_state_n = S_IDLE;
                        w_k_n     = 4'd0;
                        w_rep_n   = 4'd0;
                        w_win_n   = 1'b0;
                        w_shift_n = 2'd0;
                        w_valid_n = 1'b0;
                        w_last_n  = 1'b0;
                        w_busy_n  = 1'b0;
                        w_done_n  = !abort;
                    end else if (w_fire) begin
                        // window applies to burst sample 0 only
                        w_k_n      = w_k_inc;
                        w_rep_n    = w_rep_inc;
                        w_sample_n = shape(rom_sample(w_k_inc), r_shift, 1'b0);
                        w_last_n   = (w_k_inc == c_LAST_K) && (w_rep_inc == c_LAST_REP);
                    end
                end
            endcase
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_k      <= 4'd0;
            r_rep    <= 4'd0;
            r_win    <= 1'b0;
            r_shift  <= 2'd0;
            r_sample <= 32'd0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_k      <= w_k_n;
            r_rep    <= w_rep_n;
            r_win    <= w_win_n;
            r_shift  <= w_shift_n;
            r_sample <= w_sample_n;
            r_valid  <= w_valid_n;
            r_last   <= w_last_n;
            r_busy   <= w_busy_n;
            r_done   <= w_done_n;
        end
    end

    assign sample_out       = r_sample;
    assign sample_out_valid = r_valid;
    assign sample_out_last  = r_last;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule
`default_nettype wire
